// File: rtl/rr_chan_mux_pkg.sv
// Shared constants and helpers for the rr_chan_mux channel multiplexer.
// Optional packet locking in the top is enabled with RR_CHAN_MUX_LOCK_EN.
package rr_chan_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Next channel index with wrap from n-1 back to 0.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arb_n.sv
// Combinational N-way round-robin arbiter: grants the first requester found
// scanning upward from i_ptr+1 (mod N). The pointer register lives in the caller.
module rr_arb_n
  import rr_chan_mux_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);

  logic [SW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = i_ptr;
    // The last iteration revisits i_ptr itself, so it has the lowest priority.
    for (int k = 0; k < N; k++) begin
      w_idx = SW'(next_idx(32'(w_idx), N));
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_chan_mux.sv
// N-channel, W-bit stream multiplexer with fixed-select or round-robin arbitration
// and a registered output stage. Define RR_CHAN_MUX_LOCK_EN for packet locking.
module rr_chan_mux
  import rr_chan_mux_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  input  logic           out_ready,
`ifdef RR_CHAN_MUX_LOCK_EN
  input  logic [N-1:0]   in_last,
  output logic           out_last,
`endif
  output logic           out_valid
);

  // Handshake: a beat moves when valid & ready are both high at a rising edge.
  // Producers never wait on ready before raising valid; ready never waits on valid
  // except through the grant. The output beat holds until out_ready is seen high.

  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_chan;
  logic [SW-1:0] r_ptr;

  logic          w_load;
  logic [N-1:0]  w_rr_grant;
  logic [N-1:0]  w_fix_grant;
  logic [N-1:0]  w_grant;
  logic [SW-1:0] w_gidx;
  logic [W-1:0]  w_gdata;
  logic          w_xfer;

  // Nothing is accepted while in reset, so a producer never loses a beat to it.
  assign w_load = ~rst & (~r_out_valid | out_ready);

  rr_arb_n #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .i_req   (in_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_rr_grant)
  );

  // An out-of-range sel matches no channel and so grants nothing.
  always_comb begin
    w_fix_grant = '0;
    for (int c = 0; c < N; c++) begin
      w_fix_grant[c] = (sel == SW'(c)) & in_valid[c];
    end
  end

`ifdef RR_CHAN_MUX_LOCK_EN
  logic          r_lock;
  logic [SW-1:0] r_lock_chan;
  logic          r_out_last;

  always_comb begin
    w_grant = (mode == MODE_RR) ? w_rr_grant : w_fix_grant;
    if (r_lock) begin
      w_grant              = '0;
      w_grant[r_lock_chan] = in_valid[r_lock_chan];
    end
  end
`else
  assign w_grant = (mode == MODE_RR) ? w_rr_grant : w_fix_grant;
`endif

  always_comb begin
    w_gidx  = '0;
    w_gdata = '0;
    for (int c = 0; c < N; c++) begin
      if (w_grant[c]) begin
        w_gidx  = w_gidx | SW'(c);
        w_gdata = w_gdata | in_data[c*W +: W];
      end
    end
  end

  assign in_ready = w_grant & {N{w_load}};
  assign w_xfer   = |in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_ptr       <= SW'(N - 1);
    end else if (w_load) begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_gdata;
        r_out_chan  <= w_gidx;
        if (mode == MODE_RR) r_ptr <= w_gidx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef RR_CHAN_MUX_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock      <= 1'b0;
      r_lock_chan <= '0;
      r_out_last  <= 1'b0;
    end else if (w_xfer) begin
      r_out_last  <= in_last[w_gidx];
      r_lock      <= ~in_last[w_gidx];
      r_lock_chan <= w_gidx;
    end
  end

  assign out_last = r_out_last;
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_rr_chan_mux.sv
// Self-checking bench for rr_chan_mux: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_rr_chan_mux;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int SW = 3;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready;
`ifdef RR_CHAN_MUX_LOCK_EN
  logic [N-1:0]   in_last;
  logic           out_last;
  localparam bit  LOCK_EN = 1'b1;
`else
  localparam bit  LOCK_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  rr_chan_mux #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready),
`ifdef RR_CHAN_MUX_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  logic          m_valid = 1'b0;
  logic [W-1:0]  m_data = '0;
  int            m_chan = 0;
  int            m_ptr = N - 1;
  logic          m_last = 1'b0;
  logic          m_lock = 1'b0;
  int            m_lock_chan = 0;
  logic [W-1:0]  exp_q[$];

  // Channel that should win this cycle, or -1 for none.
  function automatic int model_grant(input logic md, input int s, input logic [N-1:0] v);
    if (m_lock) return v[m_lock_chan] ? m_lock_chan : -1;
    if (md == 1'b0) return (s < N && v[s]) ? s : -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input logic r, input logic md, input logic [SW-1:0] s,
                       input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input logic [N-1:0] last, input logic ordy,
                       output logic [N-1:0] act_rdy);
    int           g;
    logic         load;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] e;
    @(negedge clk);
    rst = r; mode = md; sel = s; in_valid = v; in_data = d; out_ready = ordy;
`ifdef RR_CHAN_MUX_LOCK_EN
    in_last = last;
`endif
    #1;
    load = !r && (!m_valid || ordy);
    g = model_grant(md, int'(s), v);
    exp_rdy = '0;
    if (load && g >= 0) exp_rdy[g] = 1'b1;
    act_rdy = in_ready;
    check("in_ready", in_ready, exp_rdy);
    if (!r && m_valid && ordy) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_underflow: got beat %0h, expected none", out_data);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", out_data, e);
      end
    end
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0; m_data = '0; m_chan = 0; m_ptr = N - 1;
      m_last = 1'b0; m_lock = 1'b0; m_lock_chan = 0;
      exp_q.delete();
    end else if (load) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = d[g*W +: W];
        m_chan  = g;
        if (md) m_ptr = g;
        exp_q.push_back(m_data);
        if (LOCK_EN) begin
          m_last      = last[g];
          m_lock      = !last[g];
          m_lock_chan = g;
        end
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check("out_valid", out_valid, m_valid);
    check("out_chan", out_chan, 64'(m_chan));
    check("out_data", out_data, m_data);
`ifdef RR_CHAN_MUX_LOCK_EN
    check("out_last", out_last, m_last);
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          r;
    logic          md;
    logic [SW-1:0] s;
    logic [N-1:0]  v;
    logic          ordy;
    logic [N-1:0]  e_rdy;
    logic          e_ov;
    logic [SW-1:0] e_ch;
    logic [W-1:0]  e_d;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(logic r, logic md, logic [SW-1:0] s, logic [N-1:0] v, logic ordy,
                               logic [N-1:0] e_rdy, logic e_ov, logic [SW-1:0] e_ch, logic [W-1:0] e_d);
    vec_t t;
    t = '{r, md, s, v, ordy, e_rdy, e_ov, e_ch, e_d};
    return t;
  endfunction

  logic [N*W-1:0] d0;
  logic [N*W-1:0] d1;
  logic [N-1:0]   rdy;
  localparam logic [N-1:0] ALL_LAST = '1;

  initial begin
    for (int c = 0; c < N; c++) begin
      d0[c*W +: W] = 8'h10 + 8'(c);
      d1[c*W +: W] = 8'hA0 + 8'(c);
    end

    // Reset held two cycles with every channel requesting.
    tbl.push_back(mkv(1, 1, 0, 8'hFF, 1, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mkv(1, 1, 0, 8'hFF, 1, 8'h00, 0, 0, 8'h00));
    // Round-robin fairness: 0..7 twice, no gaps.
    for (int k = 0; k < 16; k++)
      tbl.push_back(mkv(0, 1, 0, 8'hFF, 1, 8'(1 << (k % 8)), 1, SW'(k % 8), 8'h10 + 8'(k % 8)));
    // Fixed select on channel 5.
    for (int k = 0; k < 3; k++)
      tbl.push_back(mkv(0, 0, 5, 8'hFF, 1, 8'h20, 1, 5, 8'h15));
    // Sparse requesters 0 and 7 with wrap after channel 7.
    tbl.push_back(mkv(0, 1, 0, 8'h81, 1, 8'h01, 1, 0, 8'h10));
    tbl.push_back(mkv(0, 1, 0, 8'h81, 1, 8'h80, 1, 7, 8'h17));
    tbl.push_back(mkv(0, 1, 0, 8'h81, 1, 8'h01, 1, 0, 8'h10));
    // Fixed sel=7 with channel 7 idle: output drains, data/chan hold.
    tbl.push_back(mkv(0, 0, 7, 8'h01, 1, 8'h00, 0, 0, 8'h10));
    // Load a beat, then reset while it is held.
    tbl.push_back(mkv(0, 1, 0, 8'h10, 0, 8'h10, 1, 4, 8'h14));
    tbl.push_back(mkv(1, 1, 0, 8'hFF, 0, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mkv(0, 1, 0, 8'hFF, 1, 8'h01, 1, 0, 8'h10));
    // Backpressure for three cycles, then the next channel follows.
    for (int k = 0; k < 3; k++)
      tbl.push_back(mkv(0, 1, 0, 8'hFF, 0, 8'h00, 1, 0, 8'h10));
    tbl.push_back(mkv(0, 1, 0, 8'hFF, 1, 8'h02, 1, 1, 8'h11));
    tbl.push_back(mkv(0, 1, 0, 8'hFF, 1, 8'h04, 1, 2, 8'h12));
    // Single requester granted every cycle.
    for (int k = 0; k < 3; k++)
      tbl.push_back(mkv(0, 1, 0, 8'h08, 1, 8'h08, 1, 3, 8'h13));

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].r, tbl[i].md, tbl[i].s, tbl[i].v, d0, ALL_LAST, tbl[i].ordy, rdy);
      check($sformatf("tbl%0d_rdy", i), rdy, tbl[i].e_rdy);
      check($sformatf("tbl%0d_ov", i), out_valid, tbl[i].e_ov);
      check($sformatf("tbl%0d_ch", i), out_chan, tbl[i].e_ch);
      check($sformatf("tbl%0d_d", i), out_data, tbl[i].e_d);
    end

    // Mode/sel/data changes during a stall must not disturb the held beat.
    cycle(1, 1, 0, 8'hFF, d0, ALL_LAST, 1, rdy);
    cycle(0, 1, 0, 8'hFF, d0, ALL_LAST, 1, rdy);
    for (int k = 0; k < 2; k++) begin
      cycle(0, 0, 3, 8'hFF, d1, ALL_LAST, 0, rdy);
      check("stall_rdy", rdy, 8'h00);
      check("stall_ch", out_chan, 0);
      check("stall_d", out_data, 8'h10);
    end
    cycle(0, 0, 3, 8'hFF, d1, ALL_LAST, 1, rdy);
    check("post_stall_rdy", rdy, 8'h08);
    check("post_stall_ch", out_chan, 3);
    check("post_stall_d", out_data, 8'hA3);

`ifdef RR_CHAN_MUX_LOCK_EN
    // Channel 3 sends a 3-beat packet while all channels request.
    cycle(1, 1, 0, 8'h00, d0, ALL_LAST, 1, rdy);
    cycle(0, 1, 0, 8'h04, d0, ALL_LAST, 1, rdy);
    cycle(0, 1, 0, 8'hFF, d0, 8'hF7, 1, rdy);
    check("lock_b1_ch", out_chan, 3);
    check("lock_b1_last", out_last, 1'b0);
    cycle(0, 0, 6, 8'hFF, d0, 8'hF7, 1, rdy);
    check("lock_b2_ch", out_chan, 3);
    cycle(0, 1, 0, 8'hFF, d0, ALL_LAST, 1, rdy);
    check("lock_b3_ch", out_chan, 3);
    check("lock_b3_last", out_last, 1'b1);
    cycle(0, 1, 0, 8'hFF, d0, ALL_LAST, 1, rdy);
    check("lock_resume_ch", out_chan, 4);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      logic [N-1:0]   v;
      logic [N-1:0]   last;
      logic [N*W-1:0] d;
      case ($urandom_range(0, 3))
        0:       v = '1;
        1:       v = N'($urandom);
        2:       v = N'(1) << $urandom_range(0, N - 1);
        default: v = N'($urandom) & N'($urandom);
      endcase
      for (int c = 0; c < N; c++) begin
        d[c*W +: W] = W'($urandom);
        last[c]     = ($urandom_range(0, 9) < 7);
      end
      cycle(($urandom_range(0, 59) == 0), 1'($urandom), SW'($urandom), v, d, last,
            ($urandom_range(0, 3) != 0), rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_chan_mux.md
Name: rr_chan_mux

Overview:
- Parametrised N-channel, W-bit multiplexer; successor to the fixed 8:1 one-bit mux.
- Adds a valid/ready handshake on every input and on the output, plus a registered output stage.
- Two selection modes: fixed select (classic mux behaviour) or round-robin arbitration among valid channels.
- Sits between several producer streams and one shared consumer.

Parameters:
- N, 8, number of input channels (>=2).
- W, 8, data width per channel (>=1).
- SW, $clog2(N), select/index width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SW  channel index used in fixed mode.
- in_data  input  N*W  channel c occupies bits [c*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready (combinational).
- out_data  output  W  registered selected data.
- out_chan  output  SW  registered index of the source channel.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset values (applied on any clk edge with rst=1): out_valid=0, out_data=0, out_chan=0, rr pointer ptr=N-1, so channel 0 has first priority.
- Reset mid-transfer discards the held beat.
- Accept condition: load = ~out_valid | out_ready.
- Grant g, a combinational one-hot of width N:
  - Fixed mode: g[sel] = in_valid[sel].
  - RR mode: first c with in_valid set, scanning upward from ptr+1 modulo N (wrap N-1 -> 0).
- in_ready = g & {N{load}}, so at most one bit is high. in_ready never depends on in_valid of another channel beyond arbitration.
- Transfer on a channel when in_valid[c] & in_ready[c]. The registers then take the new beat next cycle:
  - out_data <= that channel's data.
  - out_chan <= c.
  - out_valid <= 1.
  - RR mode only: ptr <= c. Fixed mode leaves ptr unchanged.
- If out_valid & out_ready and no grant, out_valid <= 0 and out_data/out_chan hold their values.
- Stall: while out_valid & ~out_ready, out_data/out_chan/out_valid hold and all in_ready=0.
- Latency is 1 cycle input -> output. Throughput is 1 beat/cycle when out_ready is held high.
- sel >= N (non-power-of-2 N): no grant, all in_ready=0.
- mode/sel changes take effect at the next arbitration; they never alter a held output beat.
- A single valid requester in RR mode is granted every cycle (no bubble).
- With all N valid and out_ready=1, the grant order is strictly cyclic: each channel is served once per N beats.

Optional Feature:
- Macro RR_CHAN_MUX_LOCK_EN adds packet locking.
- Extra ports: in_last input N, out_last output 1 (registered, reset 0).
- Lock behaviour:
  - Accepting a beat with in_last[c]=0 sets lock=1 and lock_chan=c.
  - While locked, g is forced to lock_chan if valid, else no grant; mode, sel and ptr are ignored.
  - Accepting a beat with in_last=1 clears lock.
  - Reset clears lock.
- Without the macro there is no lock, no extra ports, and every beat is arbitrated independently.

Decomposition:
- Shared package rr_chan_mux_pkg holds:
  - Mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - Function next_idx(idx, N) for modulo wrap.
- One natural sub-module, rr_arb_n: N-bit round-robin arbiter.
  - Inputs: req and ptr.
  - Output: one-hot grant.
  - Purely combinational; the pointer register stays in the top.

Test Plan:
- Reset: hold rst=1 two cycles with in_valid=8'hFF -> out_valid=0, in_ready=0, out_chan=0. After release with mode=1, the first beat comes from channel 0.
- Fixed mode: mode=0, sel=5, in_valid=8'hFF, channel c data=8'h10+c, out_ready=1 -> only in_ready[5] high; out_data=8'h15 and out_chan=5 one cycle later, every cycle.
- Round-robin fairness: mode=1, in_valid=8'hFF, out_ready=1 for 16 cycles -> out_chan sequence 0,1,...,7,0,...,7 with no gaps.
- Backpressure: mode=1, out_ready=0 for 3 cycles after the first beat -> out_data/out_chan stable, in_ready=0. After release, the next channel follows with no beat lost or duplicated.
- Sparse/wrap: in_valid=8'b1000_0001, ptr after channel 7 -> next grant channel 0, then 7. Setting sel=7 in fixed mode with in_valid[7]=0 -> out_valid drops after drain.
- Lock (macro defined): channel 3 sends 3 beats with last on the third, all channels valid -> out_chan=3,3,3, then arbitration resumes at channel 4.
